// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared types and constants for the ALU output pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int FLAG_W = 4;

    typedef struct packed {
        logic neg;
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module  : alu_pipe_slice
// Brief   : One register slice of the ALU output pipeline (valid, result, flags).
// Revision: 1.0 - initial release
// ============================================================================
module alu_pipe_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_result,
    input  alu_flags_t       in_flags,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    // Payload loads regardless of flush; only the valid bit is invalidated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (load) begin
                r_valid <= in_valid;
            end
            if (load) begin
                r_result <= in_result;
                r_flags  <= in_flags;
            end
        end
    end

    assign valid  = r_valid;
    assign result = r_result;
    assign flags  = r_flags;

endmodule
`default_nettype wire

// File: rtl/alu_out_pipe.sv
`default_nettype none
// ============================================================================
// Module  : alu_out_pipe
// Brief   : Stallable, flushable output pipeline for ALU result and flags,
//           with sticky flag accumulation and occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module alu_out_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int STAGES = 2,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  alu_flags_t       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output alu_flags_t       out_flags,
    input  logic             flush,
    input  logic             clr_sticky,
    output alu_flags_t       sticky_flags,
    output logic [CW-1:0]    count
);

    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_res    [STAGES];
    logic [WIDTH-1:0]  w_res_in [STAGES];
    alu_flags_t        w_flg    [STAGES];
    alu_flags_t        w_flg_in [STAGES];

    logic              w_accept;
    logic              w_consume;
    logic              w_consume_eff;
    logic [CW-1:0]     r_count;
    alu_flags_t        r_sticky;

    // Ready chain walks from the output back towards the input.
    always_comb begin
        w_adv  = '0;
        w_load = '0;
        w_adv[STAGES-1]  = w_v[STAGES-1] & out_ready;
        w_load[STAGES-1] = ~w_v[STAGES-1] | w_adv[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k]  = w_v[k] & w_load[k+1];
            w_load[k] = ~w_v[k] | w_adv[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign w_v_in[k]   = in_valid;
            assign w_res_in[k] = in_result;
            assign w_flg_in[k] = in_flags;
        end else begin : g_body
            assign w_v_in[k]   = w_v[k-1];
            assign w_res_in[k] = w_res[k-1];
            assign w_flg_in[k] = w_flg[k-1];
        end

        alu_pipe_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .load      (w_load[k]),
            .flush     (flush),
            .in_valid  (w_v_in[k]),
            .in_result (w_res_in[k]),
            .in_flags  (w_flg_in[k]),
            .valid     (w_v[k]),
            .result    (w_res[k]),
            .flags     (w_flg[k])
        );
    end

    assign in_ready   = w_load[0];
    assign out_valid  = w_v[STAGES-1];
    assign out_result = out_valid ? w_res[STAGES-1] : '0;
    assign out_flags  = out_valid ? w_flg[STAGES-1] : '0;

    assign w_accept      = in_valid & in_ready;
    assign w_consume     = out_valid & out_ready;
    assign w_consume_eff = w_consume & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept && !w_consume) begin
            r_count <= r_count + CW'(1);
        end else if (!w_accept && w_consume) begin
            r_count <= r_count - CW'(1);
        end
    end

    // A clear coinciding with a consume keeps only the consumed flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sticky <= '0;
        end else if (clr_sticky) begin
            r_sticky <= w_consume_eff ? out_flags : '0;
        end else if (w_consume_eff) begin
            r_sticky <= r_sticky | out_flags;
        end
    end

    assign sticky_flags = r_sticky;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: doc/alu_out_pipe.md
# alu_out_pipe

Parametrised output pipeline for the ALU. It carries the result word and the four status flags (neg, zero, carry, ovf) through STAGES registered slices with a valid/ready handshake and a flush. It also keeps sticky flag accumulators and an occupancy count. It sits between the ALU datapath and the seven-segment/LED display logic, and replaces the single-cycle, non-stallable output flop bank.

## Interface
- WIDTH, 4: result word width, ≥1
- STAGES, 2: number of register slices, ≥1
- CW, $clog2(STAGES+1): occupancy count width (derived, not overridable)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  upstream offers a result
- in_ready  out  1  pipeline accepts this cycle
- in_result  in  WIDTH  ALU result
- in_flags  in  4  {neg, zero, carry, ovf}
- out_valid  out  1  last slice holds a result
- out_ready  in  1  downstream consumes
- out_result  out  WIDTH  result from the last slice
- out_flags  out  4  flags from the last slice
- flush  in  1  synchronous invalidate of all slices
- clr_sticky  in  1  synchronous clear of the sticky flags
- sticky_flags  out  4  OR of the flags of every result consumed since the last clear
- count  out  CW  number of valid slices

## Operation
- Each slice k holds v[k], res[k] and flg[k]. Slice 0 takes input; slice STAGES-1 drives the outputs.
- Slice k can load when !v[k] or slice k advances; the ready chain is combinational.
  - Last slice advances on out_valid & out_ready.
  - in_ready = !v[0] | adv[0].
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Data moves one slice per cycle when the next slice can load.
- Bubbles collapse: a valid slice moves into an empty successor even while the output is stalled.
- Data and flags in a non-loading slice hold their value. Data of invalid slices is don't-care internally.
- out_result/out_flags are forced to 0 when !out_valid.
- flush: all v[k] ← 0 next edge. An accept or consume in the same cycle is discarded and does not update the sticky flags. in_ready is still computed normally.
- Sticky flags update on consume only:
  - Normal: sticky ← sticky | out_flags.
  - clr_sticky alone: sticky ← 0.
  - clr_sticky with consume: sticky ← out_flags (clear first, then OR).
- count = popcount(v). It is registered alongside v, so it is always consistent with v.

## Timing
- Reset (reset=0, asynchronous) clears all v, res, flg, sticky_flags and count to 0, so out_valid=0 and in_ready=1 the cycle reset releases.
- Reset asserted mid-transfer drops all contents at once; no partial outputs.
- Latency: an input accepted at edge n appears with out_valid=1 after edge n+STAGES-1, provided nothing ahead stalls it.
- Throughput: 1 result/cycle with out_ready held at 1.
- Full: count=STAGES and out_ready=0 gives in_ready=0. Accept and consume in the same cycle while full is permitted, and count stays at STAGES.
- Empty: count=0 gives out_valid=0. An accept while empty does not bypass; minimum latency still applies.
- count changes only at clock edges: +1 on accept only, −1 on consume only, unchanged on both, 0 on flush.

## Structure
- Package alu_pkg holds:
  - typedef alu_flags_t = struct packed {neg, zero, carry, ovf}
  - localparam FLAG_W = 4
- Sub-module alu_pipe_slice: one slice holding valid, result and flags, with load and flush inputs, instantiated STAGES times via generate.
- The top level holds the ready chain, the sticky register and count.

## Test plan
- Reset: drive reset=0 mid-stream with 2 valid slices → out_valid=0, count=0, sticky=0 immediately; in_ready=1 after release.
- Streaming (WIDTH=4, STAGES=2, out_ready=1): send 3,5,9 back-to-back → out_result 3,5,9 on consecutive cycles, first one 1 cycle after accept.
- Stall/full: out_ready=0, send 1,2,3 → 1 and 2 accepted, count=2, in_ready=0 for 3. Then out_ready=1 → 1, 2, 3 emerge in order, none lost or duplicated.
- Sticky: consume flags 4'b0010 then 4'b1000 → sticky=4'b1010. Then clr_sticky with a consume of flags 4'b0001 in the same cycle → sticky=4'b0001.
- Flush: count=2, flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, sticky unchanged.
- Parameter sweep: STAGES=1 and STAGES=4, WIDTH=8, random valid/ready checked against a reference FIFO model → output order matches, and count always equals occupancy.
